// File: rtl/stream_min_finder.sv
// Streaming block-minimum finder: reports the minimum of each COUNT-sample block and the index of its first occurrence.
// Build option: define STREAM_MIN_SIGNED_EN for two's-complement comparison (default is unsigned).
module stream_min_finder #(
  parameter int WIDTH = 4,
  parameter int COUNT = 16,
  parameter int IDXW  = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_idx
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  cnt, cnt_nxt;
  logic [WIDTH-1:0] cur_min, cur_min_nxt;
  logic [IDXW-1:0]  cur_idx, cur_idx_nxt;
  logic [WIDTH-1:0] out_min_nxt;
  logic [IDXW-1:0]  out_idx_nxt;
  logic             accept;
  logic [WIDTH-1:0] blk_min;
  logic [IDXW-1:0]  blk_idx;

  function automatic logic is_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef STREAM_MIN_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // Running minimum including the sample currently offered; strict compare keeps the earliest index on ties.
  always_comb begin
    blk_min = cur_min;
    blk_idx = cur_idx;
    if ((cnt == '0) || is_less(in_data, cur_min)) begin
      blk_min = in_data;
      blk_idx = cnt;
    end else begin
      blk_min = cur_min;
      blk_idx = cur_idx;
    end
  end

  // Next-state and datapath update: clear outranks normal operation.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cur_min_nxt = cur_min;
    cur_idx_nxt = cur_idx;
    out_min_nxt = out_min;
    out_idx_nxt = out_idx;
    if (clear) begin
      state_nxt = ACCUM;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            cur_min_nxt = blk_min;
            cur_idx_nxt = blk_idx;
            if (cnt == LAST_IDX) begin
              out_min_nxt = blk_min;
              out_idx_nxt = blk_idx;
              cnt_nxt     = '0;
              state_nxt   = HOLD;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            cnt_nxt = cnt;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt = ACCUM;
          end else begin
            state_nxt = HOLD;
          end
        end
        default: begin
          state_nxt = ACCUM;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      cnt     <= '0;
      cur_min <= '0;
      cur_idx <= '0;
      out_min <= '0;
      out_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_min <= cur_min_nxt;
      cur_idx <= cur_idx_nxt;
      out_min <= out_min_nxt;
      out_idx <= out_idx_nxt;
    end
  end

endmodule
